// File: rtl/mips_debug_dump_rx_if.sv
// mips_debug_dump_rx_if: dump-receiver UART byte strobe, control and buffer read bundle
interface mips_debug_dump_rx_if #(
   parameter int DATA_BITS = 8,
   parameter int NBITS = 32,
   parameter int AW = 6
);
   logic rx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic clear;
   logic [AW-1:0] rd_addr;
   logic [NBITS-1:0] rd_data;
   logic [AW:0] word_cnt;
   logic busy;
   logic frame_done;
   logic error;
   modport master(output rx_ready, rx_data, clear, rd_addr,
                  input rd_data, word_cnt, busy, frame_done, error);
   modport slave(input rx_ready, rx_data, clear, rd_addr,
                 output rd_data, word_cnt, busy, frame_done, error);
endinterface

// File: rtl/mips_debug_dump_rx.sv
// mips_debug_dump_rx: reassembles the debug dump byte stream into a readable frame buffer.
// Define DUMP_TIMEOUT_EN to abort a frame into ERROR after TIMEOUT_CYC idle cycles.
module mips_debug_dump_rx #(
   parameter int DATA_BITS = 8,
   parameter int NBITS = 32,
   parameter int N_REGS = 32,
   parameter int N_MEM = 16,
   parameter int TIMEOUT_CYC = 500000
) (
   input logic clk,
   input logic reset,
   mips_debug_dump_rx_if.slave bus
);
   localparam int FRAME_WORDS = 2 + N_REGS + N_MEM;
   localparam int BPW = NBITS / DATA_BITS;
   localparam int IW = BPW > 1 ? $clog2(BPW) : 1;
   localparam int AW = $clog2(FRAME_WORDS);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, RECV, DONE, ERROR} state_t;
   state_t state;
   logic [IW-1:0] idx, eidx;
   logic [CW-1:0] word_cnt, ecnt;
   logic [NBITS-1:0] asm_word, nxt;
   logic [NBITS-1:0] mem [FRAME_WORDS];
   logic accept, word_end, last;
`ifdef DUMP_TIMEOUT_EN
   localparam int GW = $clog2(TIMEOUT_CYC + 1);
   logic [GW-1:0] gap;
`endif
   // A byte arriving outside RECV always starts word 0 byte 0 of a fresh frame.
   always_comb begin
      eidx = state == RECV ? idx : '0;
      ecnt = state == RECV ? word_cnt : '0;
      accept = bus.rx_ready && !bus.clear && state != ERROR;
      word_end = eidx == IW'(BPW - 1);
      last = ecnt == CW'(FRAME_WORDS - 1);
      nxt = asm_word;
      nxt[eidx*DATA_BITS +: DATA_BITS] = bus.rx_data;
   end
   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         state <= IDLE;
         idx <= '0;
         word_cnt <= '0;
         bus.busy <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.error <= 1'b0;
`ifdef DUMP_TIMEOUT_EN
         gap <= '0;
`endif
      end else if (accept) begin
         asm_word <= nxt;
         idx <= word_end ? '0 : eidx + 1'b1;
         word_cnt <= word_end ? ecnt + 1'b1 : ecnt;
         state <= word_end && last ? DONE : RECV;
         bus.busy <= !(word_end && last);
         bus.frame_done <= word_end && last;
`ifdef DUMP_TIMEOUT_EN
         gap <= '0;
`endif
      end
`ifdef DUMP_TIMEOUT_EN
      else if (state == RECV) begin
         if (gap == GW'(TIMEOUT_CYC - 1)) begin
            state <= ERROR;
            bus.busy <= 1'b0;
            bus.error <= 1'b1;
            gap <= '0;
         end else
            gap <= gap + 1'b1;
      end
`endif
   end
   // Buffer survives reset and clear; reads return the pre-write word on a collision.
   always_ff @(posedge clk) begin
      if (!reset && accept && word_end)
         mem[ecnt[AW-1:0]] <= nxt;
      bus.rd_data <= reset ? '0 :
                     {1'b0, bus.rd_addr} < CW'(FRAME_WORDS) ? mem[bus.rd_addr] : '0;
   end
   assign bus.word_cnt = word_cnt;
endmodule

// File: tb/tb_mips_debug_dump_rx.sv
// tb_mips_debug_dump_rx: directed checks of frame assembly, clear, read port and timeout.
module tb_mips_debug_dump_rx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   mips_debug_dump_rx_if #(.DATA_BITS(8), .NBITS(32), .AW(6)) bus();
   mips_debug_dump_rx #(.DATA_BITS(8), .NBITS(32), .N_REGS(32), .N_MEM(16), .TIMEOUT_CYC(100))
      dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b);
      bus.rx_ready = 1'b1;
      bus.rx_data = b;
      @(negedge clk);
      bus.rx_ready = 1'b0;
   endtask
   task automatic send_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
   endtask
   task automatic pulse_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
   endtask
   task automatic read_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
      bus.rd_addr = a;
      @(negedge clk);
      check(tag, bus.rd_data, exp);
   endtask
   initial begin
      logic [31:0] w;
      bus.rx_ready = 1'b0;
      bus.rx_data = '0;
      bus.clear = 1'b0;
      bus.rd_addr = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.frame_done, 0);
      check("rst_err", bus.error, 0);
      check("rst_cnt", bus.word_cnt, 0);
      check("rst_rd", bus.rd_data, 0);
      // Full frame, back-to-back strobes, last byte held back.
      for (int k = 0; k < 49; k++) send_word(32'hA500_0000 + k);
      send_byte(8'h31);
      send_byte(8'h00);
      send_byte(8'h00);
      check("pre_last_done", bus.frame_done, 0);
      check("pre_last_busy", bus.busy, 1);
      check("pre_last_cnt", bus.word_cnt, 49);
      send_byte(8'hA5);
      check("done", bus.frame_done, 1);
      check("done_busy", bus.busy, 0);
      check("done_cnt", bus.word_cnt, 50);
      for (int k = 0; k < 50; k++) read_chk("rd_frame", 6'(k), 32'hA500_0000 + k);
      bus.rd_addr = 6'd1;
      #1 check("rd_latency", bus.rd_data, 32'hA500_0031);
      @(negedge clk);
      check("rd_after_lat", bus.rd_data, 32'hA500_0001);
      read_chk("rd_oob50", 6'd50, 0);
      read_chk("rd_oob63", 6'd63, 0);
      check("done_held", bus.frame_done, 1);
      check("done_cnt_held", bus.word_cnt, 50);
      // New frame from DONE.
      send_byte(8'h01);
      check("restart_done", bus.frame_done, 0);
      check("restart_busy", bus.busy, 1);
      check("restart_cnt", bus.word_cnt, 0);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      check("restart_cnt1", bus.word_cnt, 1);
      read_chk("restart_w0", 6'd0, 32'h0403_0201);
      pulse_clear();
      check("clr_busy", bus.busy, 0);
      check("clr_cnt", bus.word_cnt, 0);
      // Partial frame then clear: completed word kept, partial dropped.
      w = 32'h4433_2211;
      send_word(w);
      send_byte(8'h55);
      send_byte(8'h66);
      check("part_cnt", bus.word_cnt, 1);
      pulse_clear();
      check("part_clr_cnt", bus.word_cnt, 0);
      check("part_clr_busy", bus.busy, 0);
      check("part_clr_done", bus.frame_done, 0);
      read_chk("part_w0", 6'd0, 32'h4433_2211);
      read_chk("part_w1", 6'd1, 32'hA500_0001);
      // Fresh frame after clear, reading word 0 while it is written.
      bus.rd_addr = 6'd0;
      send_byte(8'h77);
      send_byte(8'h88);
      send_byte(8'h99);
      send_byte(8'hAA);
      check("collide_old", bus.rd_data, 32'h4433_2211);
      check("fresh_cnt", bus.word_cnt, 1);
      @(negedge clk);
      check("collide_new", bus.rd_data, 32'hAA99_8877);
      // Clear beats a same-cycle byte.
      send_byte(8'h01);
      bus.clear = 1'b1;
      bus.rx_ready = 1'b1;
      bus.rx_data = 8'hEE;
      @(negedge clk);
      bus.clear = 1'b0;
      bus.rx_ready = 1'b0;
      check("clr_rx_busy", bus.busy, 0);
      check("clr_rx_cnt", bus.word_cnt, 0);
      send_word(32'h4030_2010);
      check("clr_rx_cnt1", bus.word_cnt, 1);
      read_chk("clr_rx_w0", 6'd0, 32'h4030_2010);
      pulse_clear();
`ifdef DUMP_TIMEOUT_EN
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      repeat (99) @(negedge clk);
      check("to_early_err", bus.error, 0);
      check("to_early_busy", bus.busy, 1);
      @(negedge clk);
      check("to_err", bus.error, 1);
      check("to_busy", bus.busy, 0);
      send_word(32'h1234_5678);
      check("to_ignore_cnt", bus.word_cnt, 0);
      check("to_ignore_err", bus.error, 1);
      pulse_clear();
      check("to_clr_err", bus.error, 0);
`else
      send_byte(8'h01);
      repeat (120) @(negedge clk);
      check("no_to_err", bus.error, 0);
      check("no_to_busy", bus.busy, 1);
      pulse_clear();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
